sr_mul_unit: RTL and testbench



---
 rtl/sr_mul_unit_if.sv | 27 ++
 rtl/sr_mul_unit.sv | 77 +++++++
 tb/tb_sr_mul_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_mul_unit_if.sv
// Core-side bundle for the shift-add multiplier: start/busy handshake,
// operands, product, and the borrowed main-ALU request/response path.
interface sr_mul_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic [2:0]       aluOper;
  logic [WIDTH-1:0] aluSrcA;
  logic [WIDTH-1:0] aluSrcB;
  logic [WIDTH-1:0] aluResult;

  // Core/control side: issues requests and returns the ALU result.
  modport master (
    output start, a, b, aluResult,
    input  result, busy, aluOper, aluSrcA, aluSrcB
  );

  // Multiplier side.
  modport slave (
    input  start, a, b, aluResult,
    output result, busy, aluOper, aluSrcA, aluSrcB
  );
endinterface

// File: rtl/sr_mul_unit.sv
// Multi-cycle shift-add multiplier coprocessor producing the low WIDTH bits
// of a*b (RV32M MUL). Every accumulation goes through the core's main ALU.
//
// state | meaning
// IDLE  | waiting for start; result holds the last product
// RUN   | one multiplier bit per cycle, adding mcand via the shared ALU
module sr_mul_unit #(
  parameter int       WIDTH        = 32,
  parameter bit [2:0] ALU_ADD_CODE = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  sr_mul_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             done;

  // Stop once no multiplier bits are left after this one, or on the last bit.
  assign done = ((mplier >> 1) == '0) || (cnt == CW'(WIDTH - 1));

  // Sequencer and datapath registers; shifted-out bits and carries are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            acc    <= '0;
            mcand  <= bus.a;
            mplier <= bus.b;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= bus.aluResult;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU request: add acc+mcand while running, zero operands otherwise.
  always_comb begin
    bus.aluOper = ALU_ADD_CODE;
    bus.aluSrcA = '0;
    bus.aluSrcB = '0;
    if (state == RUN) begin
      bus.aluSrcA = acc;
      bus.aluSrcB = mcand;
    end
  end

  // Stall asserts in the start cycle itself so the PC never advances past MUL.
  always_comb begin
    bus.busy = !rst && ((bus.start && (state == IDLE)) || (state == RUN));
  end

  assign bus.result = acc;
endmodule

// File: tb/tb_sr_mul_unit.sv
// Directed bench for sr_mul_unit; the bench plays the core and its main ALU.
module tb_sr_mul_unit;
  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  sr_mul_unit_if #(.WIDTH(32)) bus_if ();

  sr_mul_unit #(.WIDTH(32), .ALU_ADD_CODE(3'b000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // Core ALU stand-in: only the add opcode is meaningful here.
  assign bus_if.aluResult = (bus_if.aluOper == 3'b000) ? (bus_if.aluSrcA + bus_if.aluSrcB) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op starting at the current negedge; return when busy drops
  // (cycle N+1), so another call right after is a back-to-back start.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       output logic busy0, output int run_cycles,
                       output logic [31:0] res);
    bus_if.start = 1'b1;
    bus_if.a     = av;
    bus_if.b     = bv;
    #1 busy0 = bus_if.busy;
    @(negedge clk);
    bus_if.start = 1'b0;
    run_cycles = 0;
    while (bus_if.busy && run_cycles < 40) begin
      run_cycles++;
      @(negedge clk);
    end
    res = bus_if.result;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_if.start = 1'b1;
    bus_if.a = 32'h5;
    bus_if.b = 32'h5;
    @(negedge clk);
    @(negedge clk);
    #1;
    vec_cnt++;
    if (bus_if.busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_busy_with_start: got %b want 0", bus_if.busy);
    end
    bus_if.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (bus_if.result !== 32'h0 || bus_if.busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: result=%h busy=%b want 0/0", bus_if.result, bus_if.busy);
    end
    vec_cnt++;
    if (bus_if.aluOper !== 3'b000 || bus_if.aluSrcA !== 32'h0 || bus_if.aluSrcB !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_alu: oper=%b a=%h b=%h want 000/0/0", bus_if.aluOper, bus_if.aluSrcA, bus_if.aluSrcB);
    end
  endtask

  task automatic test_basic;
    int   runs;
    logic oper_bad;
    bus_if.start = 1'b1;
    bus_if.a = 32'd6;
    bus_if.b = 32'd7;
    #1;
    vec_cnt++;
    if (bus_if.busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL basic_busy_start: got %b want 1", bus_if.busy);
    end
    @(negedge clk);
    bus_if.start = 1'b0;
    runs = 0;
    oper_bad = 1'b0;
    while (bus_if.busy && runs < 40) begin
      if (bus_if.aluOper !== 3'b000) oper_bad = 1'b1;
      runs++;
      @(negedge clk);
    end
    vec_cnt++;
    if (runs != 3) begin
      err_cnt++;
      $display("FAIL basic_run_cycles: got %0d want 3", runs);
    end
    vec_cnt++;
    if (bus_if.result !== 32'd42) begin
      err_cnt++;
      $display("FAIL basic_result: got %0d want 42", bus_if.result);
    end
    vec_cnt++;
    if (oper_bad) begin
      err_cnt++;
      $display("FAIL basic_alu_oper: got non-add want 000");
    end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (bus_if.result !== 32'd42 || bus_if.busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_hold: result=%0d busy=%b want 42/0", bus_if.result, bus_if.busy);
    end
  endtask

  task automatic test_all_ones;
    logic b0;
    int runs;
    logic [31:0] res;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, b0, runs, res);
    vec_cnt++;
    if (runs != 32) begin
      err_cnt++;
      $display("FAIL ones_run_cycles: got %0d want 32", runs);
    end
    vec_cnt++;
    if (res !== 32'h0000_0001) begin
      err_cnt++;
      $display("FAIL ones_result: got %h want 00000001", res);
    end
  endtask

  task automatic test_back_to_back;
    logic b0;
    int runs;
    logic [31:0] res;
    do_op(32'h1234_5678, 32'h0, b0, runs, res);
    vec_cnt++;
    if (runs != 1 || res !== 32'h0) begin
      err_cnt++;
      $display("FAIL zero_b: runs=%0d result=%h want 1/0", runs, res);
    end
    do_op(32'd3, 32'd5, b0, runs, res);
    vec_cnt++;
    if (b0 !== 1'b1) begin
      err_cnt++;
      $display("FAIL b2b_accept: busy=%b want 1", b0);
    end
    vec_cnt++;
    if (runs != 3 || res !== 32'd15) begin
      err_cnt++;
      $display("FAIL b2b_result: runs=%0d result=%0d want 3/15", runs, res);
    end
  endtask

  task automatic test_overflow;
    logic b0;
    int runs;
    logic [31:0] res;
    do_op(32'h8000_0000, 32'd2, b0, runs, res);
    vec_cnt++;
    if (runs != 2 || res !== 32'h0) begin
      err_cnt++;
      $display("FAIL ovf_b2: runs=%0d result=%h want 2/00000000", runs, res);
    end
    do_op(32'h8000_0000, 32'd1, b0, runs, res);
    vec_cnt++;
    if (runs != 1 || res !== 32'h8000_0000) begin
      err_cnt++;
      $display("FAIL ovf_b1: runs=%0d result=%h want 1/80000000", runs, res);
    end
  endtask

  task automatic test_start_in_run;
    int runs;
    bus_if.start = 1'b1;
    bus_if.a = 32'd100;
    bus_if.b = 32'h100;
    @(negedge clk);
    bus_if.start = 1'b0;
    runs = 0;
    while (bus_if.busy && runs < 40) begin
      runs++;
      if (runs == 3) begin
        bus_if.start = 1'b1;
        bus_if.a = 32'd1;
        bus_if.b = 32'd1;
      end else begin
        bus_if.start = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    vec_cnt++;
    if (runs != 9) begin
      err_cnt++;
      $display("FAIL ignore_start_cycles: got %0d want 9", runs);
    end
    vec_cnt++;
    if (bus_if.result !== 32'd25600) begin
      err_cnt++;
      $display("FAIL ignore_start_result: got %0d want 25600", bus_if.result);
    end
  endtask

  task automatic test_reset_mid_run;
    int runs;
    logic b0;
    logic [31:0] res;
    bus_if.start = 1'b1;
    bus_if.a = 32'd9;
    bus_if.b = 32'hFFFF;
    @(negedge clk);
    bus_if.start = 1'b0;
    runs = 0;
    while (bus_if.busy && runs < 40) begin
      runs++;
      if (runs == 5) rst = 1'b1;
      @(negedge clk);
      if (rst) break;
    end
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (runs != 5) begin
      err_cnt++;
      $display("FAIL midrst_reach: got %0d RUN cycles want 5", runs);
    end
    vec_cnt++;
    if (bus_if.busy !== 1'b0 || bus_if.result !== 32'h0) begin
      err_cnt++;
      $display("FAIL midrst_state: busy=%b result=%h want 0/0", bus_if.busy, bus_if.result);
    end
    vec_cnt++;
    if (bus_if.aluSrcA !== 32'h0 || bus_if.aluSrcB !== 32'h0) begin
      err_cnt++;
      $display("FAIL midrst_alu: a=%h b=%h want 0/0", bus_if.aluSrcA, bus_if.aluSrcB);
    end
    @(negedge clk);
    do_op(32'd4, 32'd4, b0, runs, res);
    vec_cnt++;
    if (runs != 3 || res !== 32'd16) begin
      err_cnt++;
      $display("FAIL midrst_next: runs=%0d result=%0d want 3/16", runs, res);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a = 32'h0;
    bus_if.b = 32'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_all_ones();
    test_back_to_back();
    test_overflow();
    test_start_in_run();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
